// File: rtl/asrv32_fetch.sv
// asrv32_fetch: PC owner and word fetcher; ack -> o_valid 1 cycle, 1 instr/cycle with same-cycle ack.
// i_stall holds outputs and a one-entry skid absorbs the in-flight ack; `ASRV32_ALIGN_CHECK_EN` traps misaligned redirects.
module asrv32_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_next_pc,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_out_inst;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;
    logic        r_misaligned;

    logic        w_req;
    logic        w_ack;
    logic        w_out_free;
    logic        w_skid_pop;
    logic [31:0] w_target;
    logic        w_target_mis;

`ifdef ASRV32_ALIGN_CHECK_EN
    assign w_target     = i_next_pc;
    assign w_target_mis = |i_next_pc[1:0];
`else
    logic [1:0] w_unused_lsb;
    assign w_unused_lsb = i_next_pc[1:0];
    assign w_target     = {i_next_pc[31:2], 2'b00};
    assign w_target_mis = 1'b0;
`endif

    // Output register can take new data when empty or being consumed this cycle.
    assign w_out_free = !r_out_valid || !i_stall;
    assign w_ack      = w_req && i_ack_inst;
    assign w_skid_pop = (r_state == S_HOLD) && !i_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_change_pc) begin
            w_state_nxt = (w_req && !i_ack_inst) ? S_DRAIN : S_FETCH;
        end else begin
            case (r_state)
                S_RESET: w_state_nxt = S_FETCH;
                S_FETCH: if (w_ack && !w_out_free) w_state_nxt = S_HOLD;
                S_HOLD:  if (w_skid_pop) w_state_nxt = S_FETCH;
                S_DRAIN: if (i_ack_inst) w_state_nxt = S_FETCH;
                default: w_state_nxt = S_RESET;
            endcase
        end
    end

    // DRAIN keeps presenting the abandoned request until memory acknowledges it.
    always_comb begin
        w_req   = 1'b0;
        o_iaddr = r_pc;
        case (r_state)
            S_FETCH: w_req = !r_misaligned;
            S_DRAIN: begin
                w_req   = 1'b1;
                o_iaddr = r_drain_addr;
            end
            default: w_req = 1'b0;
        endcase
    end

    assign o_stb_inst = w_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= PC_RESET;
            r_drain_addr <= PC_RESET;
            r_out_inst   <= NOP_INST;
            r_out_pc     <= PC_RESET;
            r_out_valid  <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= PC_RESET;
            r_skid_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (i_change_pc) begin
            r_pc         <= w_target;
            r_misaligned <= w_target_mis;
            r_out_valid  <= 1'b0;
            r_out_inst   <= NOP_INST;
            r_skid_valid <= 1'b0;
            if (r_state == S_FETCH) begin
                r_drain_addr <= r_pc;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        if (w_out_free) begin
                            r_out_inst  <= i_inst;
                            r_out_pc    <= r_pc;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_skid_inst  <= i_inst;
                            r_skid_pc    <= r_pc;
                            r_skid_valid <= 1'b1;
                        end
                        r_pc <= r_pc + 32'd4;
                    end else if (w_out_free) begin
                        r_out_valid <= 1'b0;
                        r_out_inst  <= NOP_INST;
                    end
                end
                S_HOLD: begin
                    if (w_skid_pop) begin
                        r_out_inst   <= r_skid_inst;
                        r_out_pc     <= r_skid_pc;
                        r_out_valid  <= r_skid_valid;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    if (w_out_free) begin
                        r_out_valid <= 1'b0;
                        r_out_inst  <= NOP_INST;
                    end
                end
            endcase
        end
    end

    assign o_inst       = r_out_inst;
    assign o_pc         = r_out_pc;
    assign o_valid      = r_out_valid;
    assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Scoreboard bench for asrv32_fetch: a memory responder, directed phases, then randomized stall/redirect/reset.
module tb_asrv32_fetch;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_stall = 1'b0;
    logic        i_change_pc = 1'b0;
    logic [31:0] i_next_pc = 32'h0;
    logic        o_misaligned;

    always #5 clk = ~clk;

    asrv32_fetch #(.PC_RESET(PC_RST), .NOP_INST(NOP)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
        .i_ack_inst(i_ack_inst), .i_inst(i_inst),
        .o_inst(o_inst), .o_pc(o_pc), .o_valid(o_valid),
        .i_stall(i_stall), .i_change_pc(i_change_pc), .i_next_pc(i_next_pc),
        .o_misaligned(o_misaligned)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_next;
    bit          exp_active = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          consumed = 0;

    int          lat_fixed = 0;
    bit          lat_rand = 1'b0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // The decoder must see target, target+4, ... after every redirect or reset.
    task automatic refill(input logic [31:0] target);
        exp_q.delete();
        exp_next   = target;
        exp_active = 1'b1;
        while (exp_q.size() < 64) begin
            exp_q.push_back({exp_next, mem_f(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic kill_stream();
        exp_q.delete();
        exp_active = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        i_rst = 1'b1;
        i_change_pc = 1'b0;
        refill(PC_RST);
        repeat (2) step();
        i_rst = 1'b0;
    endtask

    // Memory: acks after a programmable number of wait cycles, data is a fixed function of address.
    int resp_cnt = 0;
    int resp_lat = 0;
    initial begin
        i_ack_inst = 1'b0;
        i_inst     = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (o_stb_inst === 1'b1) begin
                if (resp_cnt >= resp_lat) begin
                    i_ack_inst = 1'b1;
                    i_inst     = mem_f(o_iaddr);
                    resp_cnt   = 0;
                    resp_lat   = lat_rand ? int'($urandom_range(3, 0)) : lat_fixed;
                end else begin
                    i_ack_inst = 1'b0;
                    i_inst     = $urandom;
                    resp_cnt++;
                end
            end else begin
                i_ack_inst = 1'b0;
                resp_cnt   = 0;
            end
        end
    end

    // Monitor: request stability and in-order consumption against the expected stream.
    logic        p_stb = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
    logic [31:0] p_addr = 32'h0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p_stb === 1'b1 && p_ack === 1'b0 && p_rst === 1'b0) begin
                chk("stb_held", {31'h0, o_stb_inst}, 32'h1);
                chk("iaddr_held", o_iaddr, p_addr);
            end
            if (i_rst === 1'b0 && i_change_pc === 1'b0 && o_valid === 1'b1 && i_stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h with no instruction required (t=%0t)", o_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", o_pc, e.pc);
                    chk("out_inst", o_inst, e.inst);
                    consumed++;
                    while (exp_active && exp_q.size() < 32) begin
                        exp_q.push_back({exp_next, mem_f(exp_next)});
                        exp_next = exp_next + 32'd4;
                    end
                end
            end
            p_stb  = o_stb_inst;
            p_ack  = i_ack_inst;
            p_rst  = i_rst;
            p_addr = o_iaddr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p_hold;
        int          v, viol, c0, r;
        bit          prev_v, found;

        // Reset state and first-fetch latency with zero-wait memory.
        lat_fixed = 0;
        do_reset();
        sample();
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_stb", {31'h0, o_stb_inst}, 32'h0);
        chk("rst_inst", o_inst, NOP);
        chk("rst_pc", o_pc, PC_RST);
        chk("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
        step(); sample();
        chk("first_stb", {31'h0, o_stb_inst}, 32'h1);
        chk("first_iaddr", o_iaddr, PC_RST);
        chk("first_valid", {31'h0, o_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(); sample();
            chk("stream_valid", {31'h0, o_valid}, 32'h1);
            chk("stream_pc", o_pc, PC_RST + 32'(4 * k));
        end

        // Stall four cycles: outputs frozen, fetch parks in HOLD, skid entry follows release.
        step();
        i_stall = 1'b1;
        p_hold  = exp_q[0].pc;
        sample();
        chk("stall_valid", {31'h0, o_valid}, 32'h1);
        chk("stall_pc", o_pc, p_hold);
        repeat (3) begin
            step(); sample();
            chk("hold_stb", {31'h0, o_stb_inst}, 32'h0);
            chk("hold_valid", {31'h0, o_valid}, 32'h1);
            chk("hold_pc", o_pc, p_hold);
        end
        step();
        i_stall = 1'b0;
        sample();
        chk("release_pc", o_pc, p_hold);
        step(); sample();
        chk("skid_pc", o_pc, p_hold + 32'd4);
        chk("skid_restart_stb", {31'h0, o_stb_inst}, 32'h1);

        // Three wait states: one valid pulse per four-cycle request.
        lat_fixed = 3;
        repeat (6) step();
        v = 0; viol = 0; prev_v = 1'b0;
        repeat (40) begin
            step(); sample();
            if (o_valid) begin
                v++;
                if (prev_v) viol++;
            end
            prev_v = o_valid;
        end
        chk("lat3_back_to_back", 32'(viol), 32'h0);
        chk("lat3_pulse_count", {31'h0, (v >= 9 && v <= 11)}, 32'h1);

        // Redirect to 0x100 while the request to 0x8 is waiting.
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(); sample();
            if (o_stb_inst && o_iaddr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk("saw_req_8", {31'h0, found}, 32'h1);
        step();
        i_change_pc = 1'b1;
        i_next_pc   = 32'h100;
        refill(32'h100);
        sample();
        chk("redir_no_ack", {31'h0, i_ack_inst}, 32'h0);
        step();
        i_change_pc = 1'b0;
        sample();
        chk("drain_stb", {31'h0, o_stb_inst}, 32'h1);
        chk("drain_iaddr", o_iaddr, 32'h8);
        chk("drain_valid", {31'h0, o_valid}, 32'h0);
        found = 1'b0; viol = 0;
        for (int k = 0; k < 20; k++) begin
            step(); sample();
            if (o_valid) viol++;
            if (o_stb_inst && o_iaddr == 32'h100) begin
                found = 1'b1;
                break;
            end
        end
        chk("redir_target_fetched", {31'h0, found}, 32'h1);
        chk("drain_no_valid", 32'(viol), 32'h0);

        // Redirect in the same cycle as an ack.
        lat_fixed = 0;
        repeat (10) step();
        i_change_pc = 1'b1;
        i_next_pc   = 32'h100;
        refill(32'h100);
        sample();
        chk("same_cycle_ack", {31'h0, o_stb_inst & i_ack_inst}, 32'h1);
        step();
        i_change_pc = 1'b0;
        sample();
        chk("sc_iaddr", o_iaddr, 32'h100);
        chk("sc_stb", {31'h0, o_stb_inst}, 32'h1);
        chk("sc_valid", {31'h0, o_valid}, 32'h0);
        step(); sample();
        chk("sc_first_valid", {31'h0, o_valid}, 32'h1);
        chk("sc_first_pc", o_pc, 32'h100);

        // Misaligned redirect target.
        step();
        i_change_pc = 1'b1;
        i_next_pc   = 32'h102;
`ifdef ASRV32_ALIGN_CHECK_EN
        kill_stream();
        step();
        i_change_pc = 1'b0;
        sample();
        chk("mis_flag", {31'h0, o_misaligned}, 32'h1);
        chk("mis_stb", {31'h0, o_stb_inst}, 32'h0);
        repeat (4) begin
            step(); sample();
            chk("mis_idle_stb", {31'h0, o_stb_inst}, 32'h0);
            chk("mis_idle_flag", {31'h0, o_misaligned}, 32'h1);
        end
        step();
        i_change_pc = 1'b1;
        i_next_pc   = 32'h200;
        refill(32'h200);
        step();
        i_change_pc = 1'b0;
        sample();
        chk("mis_clear", {31'h0, o_misaligned}, 32'h0);
        chk("mis_resume_stb", {31'h0, o_stb_inst}, 32'h1);
        chk("mis_resume_iaddr", o_iaddr, 32'h200);
`else
        refill(32'h100);
        step();
        i_change_pc = 1'b0;
        sample();
        chk("mis_flag_off", {31'h0, o_misaligned}, 32'h0);
        chk("mis_aligned_stb", {31'h0, o_stb_inst}, 32'h1);
        chk("mis_aligned_iaddr", o_iaddr, 32'h100);
`endif
        repeat (5) step();

        // PC wraps past 2^32.
        i_change_pc = 1'b1;
        i_next_pc   = 32'hFFFF_FFF8;
        refill(32'hFFFF_FFF8);
        step();
        i_change_pc = 1'b0;
        c0 = consumed;
        repeat (8) step();
        sample();
        chk("wrap_progress", {31'h0, (consumed - c0) >= 4}, 32'h1);

        // Randomized stalls, latencies, redirects and resets.
        lat_rand = 1'b1;
        c0 = consumed;
        for (int k = 0; k < 3000; k++) begin
            step();
            r = int'($urandom_range(999, 0));
            i_rst       = 1'b0;
            i_change_pc = 1'b0;
            if (r < 3) begin
                i_rst = 1'b1;
                refill(PC_RST);
            end else if (r < 33) begin
                i_change_pc = 1'b1;
                i_next_pc   = (r < 8) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
                refill(i_next_pc);
            end
            i_stall = ($urandom_range(9, 0) < 3);
        end
        step();
        i_rst = 1'b0; i_change_pc = 1'b0; i_stall = 1'b0;
        repeat (10) step();
        sample();
        chk("random_progress", {31'h0, (consumed - c0) > 300}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/asrv32_fetch.md
# asrv32_fetch

Instruction fetch stage of the ASRV32 core: owns the program counter, issues word requests to instruction memory over a strobe/acknowledge interface, and presents each fetched instruction with its PC to the decode stage through a valid/stall handshake. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled. Redirects from branch/jump resolution flush in-flight work and restart fetch at the new target.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INST`, default 32'h0000_0013: value driven on `o_inst` when nothing valid (addi x0,x0,0).

Ports:
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `o_iaddr` out 32: instruction memory word address (byte address, bits [1:0]=0).
- `o_stb_inst` out 1: memory request valid.
- `i_ack_inst` in 1: memory response valid; may assert in the same cycle as `o_stb_inst`.
- `i_inst` in 32: memory read data, sampled when `i_ack_inst`=1.
- `o_inst` out 32: instruction to decoder.
- `o_pc` out 32: PC of `o_inst`.
- `o_valid` out 1: `o_inst`/`o_pc` valid.
- `i_stall` in 1: decoder cannot accept; hold outputs.
- `i_change_pc` in 1: redirect request.
- `i_next_pc` in 32: redirect target.
- `o_misaligned` out 1: misaligned redirect target (see Configuration).

## Operation
- States: RESET, FETCH (one request outstanding), HOLD (no request; skid full), DRAIN (outstanding request to be discarded).
- Priority per cycle: `i_rst` > `i_change_pc` > ack/stall handling.
- RESET: entered on `i_rst`; pc=`PC_RESET`, `o_stb_inst`=0, `o_valid`=0, `o_inst`=`NOP_INST`, `o_pc`=`PC_RESET`, skid empty, `o_misaligned`=0. Next cycle without reset -> FETCH.
- FETCH: `o_stb_inst`=1, `o_iaddr`=pc, both stable until `i_ack_inst`. Exactly one request outstanding.
- On ack, no redirect: if output register free (`o_valid`=0 or `i_stall`=0), load `o_inst`=`i_inst`, `o_pc`=`o_iaddr`, `o_valid`=1; else write to skid. pc<=pc+4 (wraps modulo 2^32). If skid now full -> HOLD, else stay FETCH with next request.
- Output consumed when `o_valid`=1 and `i_stall`=0; if no new data and skid empty, `o_valid`<=0 and `o_inst`<=`NOP_INST`.
- HOLD: `o_stb_inst`=0. When `i_stall`=0, skid moves to output, skid empties -> FETCH.
- Redirect (`i_change_pc`=1): pc<=`i_next_pc`; `o_valid`<=0, `o_inst`<=`NOP_INST`; skid cleared. If a request is outstanding and not acked this cycle -> DRAIN; otherwise (ack same cycle, or none outstanding) -> FETCH at new pc, ack data discarded.
- DRAIN: `o_stb_inst` stays 1 with old `o_iaddr` (protocol: request held until ack); on ack discard data -> FETCH at redirected pc. Further redirects in DRAIN update pc only.
- `i_stall` with `o_valid`=0 has no effect.

## Timing
- First request: `o_stb_inst`=1 in the first cycle after `i_rst` deasserts.
- Ack -> `o_valid`: 1 cycle (registered).
- Throughput: 1 instruction/cycle when memory acks in the same cycle as strobe and `i_stall`=0.
- Redirect -> new address on `o_iaddr`: next cycle (no outstanding) or cycle after draining ack.
- Stall release with skid full: skid entry on outputs next cycle; new request same cycle.
- Reset mid-operation: all state to reset values at the edge; outstanding ack after reset ignored.

## Configuration
- `ASRV32_ALIGN_CHECK_EN` defined: redirect with `i_next_pc[1:0]`!=0 sets `o_misaligned`=1, does not issue requests (`o_stb_inst`=0 once any outstanding request drains), held until next aligned redirect or reset; aligned redirect clears it and resumes.
- Undefined: `i_next_pc[1:0]` ignored (forced to 0), `o_misaligned` tied 0.

## Test plan
- Reset then ack every strobe same cycle, `i_stall`=0 -> `o_pc` 0x0,0x4,0x8 on consecutive cycles starting 2 cycles after reset release, `o_inst` matches memory.
- Ack with 3-cycle latency -> `o_iaddr` stable across wait, `o_valid` pulses once per ack, `o_pc` increments by 4.
- Hold `i_stall`=1 for 4 cycles with valid output -> outputs frozen, one ack to skid, `o_stb_inst`=0 in HOLD; release -> skid instruction (pc+4) appears next cycle, no loss/duplicate.
- `i_change_pc`=1, `i_next_pc`=0x100 while request to 0x8 outstanding -> 0x8 data discarded, next `o_iaddr`=0x100, `o_valid`=0 until 0x100 returns.
- Redirect and ack in same cycle -> ack data dropped, next request 0x100 next cycle.
- With `ASRV32_ALIGN_CHECK_EN`: redirect to 0x102 -> `o_misaligned`=1, no strobes; redirect to 0x200 -> cleared, fetch 0x200. Without macro: 0x102 fetches 0x100.
